// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: opcode encodings, FSM state type, flag pin indices and
// small opcode classification helpers shared by the sequential ALU.
package alu_seq_pkg;

  // Opcode encodings; 9..15 are illegal and pass operand A through.
  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_OR  = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_XOR = 4'd3;
  localparam logic [3:0] OP_LSL = 4'd4;
  localparam logic [3:0] OP_LSR = 4'd5;
  localparam logic [3:0] OP_ASR = 4'd6;
  localparam logic [3:0] OP_ROR = 4'd7;
  localparam logic [3:0] OP_MUL = 4'd8;

  // Control FSM states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Bit positions used when the flags are packed onto a status byte.
  localparam int FLAG_OV   = 5;
  localparam int FLAG_ZERO = 6;
  localparam int FLAG_C    = 7;

  // True for the four bit-serial shift/rotate opcodes.
  function automatic logic is_shift(input logic [3:0] op);
    return (op >= OP_LSL) && (op <= OP_ROR);
  endfunction

  // True for the shift-add multiply.
  function automatic logic is_mul(input logic [3:0] op);
    return op == OP_MUL;
  endfunction

  // True for the ops finished by the single-cycle core (ADD and logic).
  function automatic logic is_core_op(input logic [3:0] op);
    return op <= OP_XOR;
  endfunction

endpackage

// File: rtl/alu_seq_core.sv
// alu_seq_core: purely combinational single-cycle ADD / OR / AND / XOR unit.
// The caller supplies B already conditionally inverted; carry and overflow
// are only meaningful for ADD and are forced to zero for the logic ops.
module alu_seq_core #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_bp,
  input  logic             i_cin,
  input  logic [1:0]       i_op,
  output logic [WIDTH-1:0] o_res,
  output logic             o_cout,
  output logic             o_ovf
);
  import alu_seq_pkg::*;

  logic [WIDTH:0] w_sum;

  // One extra bit on the adder captures the carry-out.
  assign w_sum = {1'b0, i_a} + {1'b0, i_bp} + {{WIDTH{1'b0}}, i_cin};

  // Select the arithmetic or logic result and the matching flags.
  // NOTE: every output gets a default before the case so no path leaves it unassigned, which would infer a latch.
  always_comb begin
    o_res  = w_sum[WIDTH-1:0];
    o_cout = 1'b0;
    o_ovf  = 1'b0;
    case (i_op)
      OP_ADD[1:0]: begin
        o_res  = w_sum[WIDTH-1:0];
        o_cout = w_sum[WIDTH];
        // Signed overflow: like-signed operands giving an opposite-signed sum.
        o_ovf  = (i_a[WIDTH-1] == i_bp[WIDTH-1]) && (w_sum[WIDTH-1] != i_a[WIDTH-1]);
      end
      OP_OR[1:0]:  o_res = i_a | i_bp;
      OP_AND[1:0]: o_res = i_a & i_bp;
      default:     o_res = i_a ^ i_bp;
    endcase
  end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: parametrised multi-cycle ALU with valid/ready on both sides.
// ADD/logic/illegal ops and zero-length shifts finish in one cycle through
// alu_seq_core; shifts/rotates move one bit per cycle and MUL runs one
// shift-add step per cycle over a 2*WIDTH accumulator. Results and flags are
// registered and held until the consumer takes them.
module alu_seq #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  input  logic             cin,
  input  logic             b_inv,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] hi,
  output logic             c,
  output logic             zero,
  output logic             overflow,
  output logic             negative
);
  import alu_seq_pkg::*;

  // Counter must reach WIDTH for MUL, so it is one bit wider than a shift amount.
  localparam int             CNT_W   = SHW + 1;
  localparam logic [SHW:0]   CNT_ONE = CNT_W'(1);
  localparam logic [SHW:0]   CNT_MUL = CNT_W'(WIDTH);

  // Control and output registers.
  state_t             r_state;
  logic [WIDTH-1:0]   r_s;
  logic [WIDTH-1:0]   r_hi;
  logic               r_c;
  logic               r_zero;
  logic               r_ov;
  logic               r_neg;
  logic               r_out_valid;

  // Operation context latched at acceptance.
  logic [3:0]         r_op;
  logic               r_cin;
  logic [WIDTH-1:0]   r_mcand;
  logic [2*WIDTH-1:0] r_acc;
  logic [SHW:0]       r_cnt;

  // Single-cycle path.
  logic [WIDTH-1:0]   w_bp;
  logic [SHW-1:0]     w_amt;
  logic [WIDTH-1:0]   w_core_res;
  logic               w_core_c;
  logic               w_core_ov;
  logic [WIDTH-1:0]   w_one_s;
  logic               w_one_c;
  logic               w_one_ov;
  logic               w_one_cycle;

  // Iterative path.
  logic [WIDTH-1:0]   w_work;
  logic [WIDTH-1:0]   w_step;
  logic               w_out_bit;
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_mul_next;
  logic [2*WIDTH-1:0] w_acc_next;
  logic [WIDTH-1:0]   w_fin_s;
  logic [WIDTH-1:0]   w_fin_hi;
  logic               w_fin_c;

  assign w_bp  = b_inv ? ~b : b;
  assign w_amt = b[SHW-1:0];

  alu_seq_core #(.WIDTH(WIDTH)) u_core (
    .i_a    (a),
    .i_bp   (w_bp),
    .i_cin  (cin),
    .i_op   (op[1:0]),
    .o_res  (w_core_res),
    .o_cout (w_core_c),
    .o_ovf  (w_core_ov)
  );

  // Ops with no iteration: core ops use the core, everything else (illegal
  // opcodes, zero-length shifts) passes A through with clear flags.
  always_comb begin
    w_one_s  = a;
    w_one_c  = 1'b0;
    w_one_ov = 1'b0;
    if (is_core_op(op)) begin
      w_one_s  = w_core_res;
      w_one_c  = w_core_c;
      w_one_ov = w_core_ov;
    end
  end

  assign w_one_cycle = !is_mul(op) && !(is_shift(op) && (w_amt != '0));

  // Shift operand lives in the low half of the accumulator.
  assign w_work = r_acc[WIDTH-1:0];

  // One-bit shift/rotate step and the bit it pushes out.
  always_comb begin
    w_step    = w_work;
    w_out_bit = 1'b0;
    case (r_op)
      OP_LSL: begin
        w_step    = {w_work[WIDTH-2:0], r_cin};
        w_out_bit = w_work[WIDTH-1];
      end
      OP_LSR: begin
        w_step    = {r_cin, w_work[WIDTH-1:1]};
        w_out_bit = w_work[0];
      end
      OP_ASR: begin
        w_step    = {w_work[WIDTH-1], w_work[WIDTH-1:1]};
        w_out_bit = w_work[0];
      end
      OP_ROR: begin
        w_step    = {w_work[0], w_work[WIDTH-1:1]};
        w_out_bit = w_work[0];
      end
      default: ;
    endcase
  end

  // Shift-add step: conditionally add the multiplicand to the high half,
  // then shift the whole accumulator right keeping the adder carry.
  assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                    + (r_acc[0] ? {1'b0, r_mcand} : {(WIDTH+1){1'b0}});
  assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

  assign w_acc_next = is_mul(r_op) ? w_mul_next : {r_acc[2*WIDTH-1:WIDTH], w_step};

  // Values registered on the final iteration.
  assign w_fin_s  = w_acc_next[WIDTH-1:0];
  assign w_fin_hi = is_mul(r_op) ? w_acc_next[2*WIDTH-1:WIDTH] : '0;
  assign w_fin_c  = is_mul(r_op) ? (w_fin_hi != '0) : w_out_bit;

  // Control FSM, operand capture, iteration and result registers.
  // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
  // NOTE: datapath context registers are reset too; it costs little and keeps post-reset state fully defined.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_s         <= '0;
      r_hi        <= '0;
      r_c         <= 1'b0;
      r_zero      <= 1'b0;
      r_ov        <= 1'b0;
      r_neg       <= 1'b0;
      r_out_valid <= 1'b0;
      r_op        <= OP_ADD;
      r_cin       <= 1'b0;
      r_mcand     <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_op    <= op;
            r_cin   <= cin;
            r_mcand <= a;
            if (w_one_cycle) begin
              r_s         <= w_one_s;
              r_hi        <= '0;
              r_c         <= w_one_c;
              r_ov        <= w_one_ov;
              r_zero      <= (w_one_s == '0);
              r_neg       <= w_one_s[WIDTH-1];
              r_out_valid <= 1'b1;
              r_state     <= ST_DONE;
            end else if (is_mul(op)) begin
              r_acc   <= {{WIDTH{1'b0}}, b};
              r_cnt   <= CNT_MUL;
              r_state <= ST_RUN;
            end else begin
              r_acc   <= {{WIDTH{1'b0}}, a};
              r_cnt   <= {1'b0, w_amt};
              r_state <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          r_acc <= w_acc_next;
          r_cnt <= r_cnt - CNT_ONE;
          if (r_cnt == CNT_ONE) begin
            r_s         <= w_fin_s;
            r_hi        <= w_fin_hi;
            r_c         <= w_fin_c;
            r_ov        <= 1'b0;
            r_zero      <= (w_fin_s == '0) && (w_fin_hi == '0);
            r_neg       <= w_fin_s[WIDTH-1];
            r_out_valid <= 1'b1;
            r_state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Ready depends only on state and reset so it never combinationally follows in_valid.
  assign in_ready  = (r_state == ST_IDLE) && !rst;
  assign out_valid = r_out_valid;
  assign s         = r_s;
  assign hi        = r_hi;
  assign c         = r_c;
  assign zero      = r_zero;
  assign overflow  = r_ov;
  assign negative  = r_neg;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: randomized and directed bench for alu_seq (WIDTH=8) with a
// behavioural reference model and a per-cycle compare process.
module tb_alu_seq;
  import alu_seq_pkg::*;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [3:0]   op;
  logic         cin;
  logic         b_inv;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] s;
  logic [W-1:0] hi;
  logic         c;
  logic         zero;
  logic         overflow;
  logic         negative;

  alu_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .cin       (cin),
    .b_inv     (b_inv),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .hi        (hi),
    .c         (c),
    .zero      (zero),
    .overflow  (overflow),
    .negative  (negative)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] s;
    logic [W-1:0] hi;
    logic         c;
    logic         z;
    logic         ov;
    logic         n;
    int           lat;
  } exp_t;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] pack_flags(input logic fc, fz, fov, fn);
    logic [7:0] f;
    f = '0;
    f[FLAG_C]    = fc;
    f[FLAG_ZERO] = fz;
    f[FLAG_OV]   = fov;
    f[0]         = fn;
    return f;
  endfunction

  function automatic logic [31:0] pack_exp(input exp_t e);
    return {e.s, e.hi, pack_flags(e.c, e.z, e.ov, e.n), 8'(e.lat)};
  endfunction

  // Reference model: results straight from the arithmetic definition of each op.
  function automatic exp_t model(input logic [W-1:0] ma, mb, input logic [3:0] mop,
                                 input logic mcin, mbinv);
    exp_t   e;
    longint mask, ua, ub, bp, r, sa, sb, ss, half, full;
    int     k, ci;
    logic   fill;
    mask = (longint'(1) << W) - 1;
    half = longint'(1) << (W - 1);
    full = longint'(1) << W;
    ua   = longint'(ma);
    ub   = longint'(mb);
    ci   = int'(mcin);
    bp   = mbinv ? (~ub & mask) : ub;
    k    = int'(mb) % W;
    r    = 0;
    e.s  = ma;
    e.hi = '0;
    e.c  = 1'b0;
    e.ov = 1'b0;
    e.lat = 1;
    case (mop)
      4'd0: begin
        r   = ua + bp + longint'(ci);
        e.s = r[W-1:0];
        e.c = r[W];
        sa  = (ua >= half) ? ua - full : ua;
        sb  = (bp >= half) ? bp - full : bp;
        ss  = sa + sb + longint'(ci);
        e.ov = (ss > half - 1) || (ss < -half);
      end
      4'd1: begin r = ua | bp; e.s = r[W-1:0]; end
      4'd2: begin r = ua & bp; e.s = r[W-1:0]; end
      4'd3: begin r = ua ^ bp; e.s = r[W-1:0]; end
      4'd4: begin
        r   = (ua << k) | (mcin ? ((longint'(1) << k) - 1) : 0);
        e.s = r[W-1:0];
        e.c = (k > 0) ? ua[W-k] : 1'b0;
      end
      4'd5, 4'd6: begin
        fill = (mop == 4'd6) ? ma[W-1] : mcin;
        r    = (ua >> k) | (fill ? (mask ^ (mask >> k)) : 0);
        e.s  = r[W-1:0];
        e.c  = (k > 0) ? ua[k-1] : 1'b0;
      end
      4'd7: begin
        r   = (ua >> k) | (ua << (W - k));
        e.s = r[W-1:0];
        e.c = (k > 0) ? ua[k-1] : 1'b0;
      end
      4'd8: begin
        r    = ua * ub;
        e.s  = r[W-1:0];
        e.hi = r[2*W-1:W];
        e.c  = (e.hi != '0);
        e.lat = W + 1;
      end
      default: e.s = ma;
    endcase
    if (mop >= 4'd4 && mop <= 4'd7) e.lat = 1 + k;
    e.z = (e.s == '0) && (e.hi == '0);
    e.n = e.s[W-1];
    return e;
  endfunction

  // Model state owned by the compare process.
  int           edge_n  = 0;
  bit           pending = 1'b0;
  int           v_edge  = 0;
  exp_t         cur;
  bit           exp_ovld;
  logic [W-1:0] got_s;
  logic [W-1:0] got_hi;
  logic [7:0]   got_f;

  // Compare process: advance the model on each rising edge, check #1 later.
  initial begin
    forever begin
      @(posedge clk);
      edge_n++;
      if (rst) begin
        pending = 1'b0;
      end else if (pending) begin
        if (edge_n > v_edge && out_ready) pending = 1'b0;
      end else if (in_valid) begin
        cur     = model(a, b, op, cin, b_inv);
        pending = 1'b1;
        v_edge  = edge_n + cur.lat - 1;
      end
      #1;
      exp_ovld = pending && (edge_n >= v_edge);
      check("in_ready", 64'(in_ready), 64'(!rst && !pending));
      check("out_valid", 64'(out_valid), 64'(exp_ovld));
      if (rst) begin
        check("reset_outputs", {s, hi, pack_flags(c, zero, overflow, negative)}, 64'd0);
      end else if (exp_ovld) begin
        check("result", {s, hi, pack_flags(c, zero, overflow, negative)},
              {cur.s, cur.hi, pack_flags(cur.c, cur.z, cur.ov, cur.n)});
        got_s  = s;
        got_hi = hi;
        got_f  = pack_flags(c, zero, overflow, negative);
      end
    end
  end

  task automatic wait_done(input string name);
    int g;
    g = 0;
    while (pending && g < 200) begin
      @(negedge clk);
      g++;
    end
    check(name, 64'(g >= 200), 64'd0);
  endtask

  // Issue one op with out_ready held high and wait for its transfer.
  task automatic run_op(input logic [W-1:0] ta, tb, input logic [3:0] top,
                        input logic tcin, tbinv);
    @(negedge clk);
    a = ta; b = tb; op = top; cin = tcin; b_inv = tbinv;
    in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    wait_done("op_timeout");
  endtask

  // Issue one random op with random output stalls and ignored competing offers.
  task automatic rand_op();
    int g;
    @(negedge clk);
    a = W'($urandom); b = W'($urandom);
    op = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
    cin = 1'($urandom); b_inv = 1'($urandom);
    in_valid = 1'b1; out_ready = 1'($urandom);
    g = 0;
    @(negedge clk);
    while (pending && g < 200) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if (!out_ready) begin
        in_valid = 1'($urandom);
        a = W'($urandom); b = W'($urandom); op = 4'($urandom);
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      g++;
    end
    in_valid = 1'b0;
    check("rand_timeout", 64'(g >= 200), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; op = '0; cin = 1'b0; b_inv = 1'b0;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_reset", 64'(in_ready), 64'd1);

    // Pin the model against hand-computed values.
    e = model(8'h7F, 8'h01, OP_ADD, 1'b0, 1'b0); check("pin_add", 64'(pack_exp(e)), 64'h80002101);
    e = model(8'h05, 8'h05, OP_ADD, 1'b1, 1'b1); check("pin_sub", 64'(pack_exp(e)), 64'h0000C001);
    e = model(8'h81, 8'h03, OP_LSR, 1'b0, 1'b0); check("pin_lsr", 64'(pack_exp(e)), 64'h10000004);
    e = model(8'h01, 8'h01, OP_ROR, 1'b0, 1'b0); check("pin_ror", 64'(pack_exp(e)), 64'h80008102);
    e = model(8'h80, 8'h07, OP_ASR, 1'b0, 1'b0); check("pin_asr", 64'(pack_exp(e)), 64'hFF000108);
    e = model(8'hFF, 8'hFF, OP_MUL, 1'b0, 1'b0); check("pin_mul", 64'(pack_exp(e)), 64'h01FE8009);
    e = model(8'h00, 8'h37, OP_MUL, 1'b0, 1'b0); check("pin_mul0", 64'(pack_exp(e)), 64'h00004009);

    // Directed ops; the compare process checks timing, these pin the held result.
    run_op(8'h7F, 8'h01, OP_ADD, 1'b0, 1'b0);
    check("add_ovf", {got_s, got_hi, got_f}, 64'h800021);
    run_op(8'h05, 8'h05, OP_ADD, 1'b1, 1'b1);
    check("sub_zero", {got_s, got_hi, got_f}, 64'h0000C0);
    run_op(8'h81, 8'h03, OP_LSR, 1'b0, 1'b0);
    check("lsr3", {got_s, got_hi, got_f}, 64'h100000);
    run_op(8'h01, 8'h01, OP_ROR, 1'b0, 1'b0);
    check("ror1", {got_s, got_hi, got_f}, 64'h800081);
    run_op(8'h80, 8'h07, OP_ASR, 1'b0, 1'b0);
    check("asr7", {got_s, got_hi, got_f}, 64'hFF0001);
    run_op(8'hFF, 8'hFF, OP_MUL, 1'b0, 1'b0);
    check("mul_ff", {got_s, got_hi, got_f}, 64'h01FE80);
    run_op(8'h00, 8'h37, OP_MUL, 1'b0, 1'b0);
    check("mul_zero", {got_s, got_hi, got_f}, 64'h000040);
    run_op(8'hA5, 8'h00, OP_LSL, 1'b1, 1'b0);
    check("lsl0_pass", {got_s, got_hi, got_f}, 64'hA50001);

    // Backpressure with a competing offer that must be ignored.
    @(negedge clk);
    a = 8'h10; b = 8'h20; op = OP_ADD; cin = 1'b0; b_inv = 1'b0;
    in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    repeat (5) begin
      a = 8'hAA; b = 8'h55; op = OP_MUL; in_valid = 1'b1;
      @(negedge clk);
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_hold_s", 64'(s), 64'h30);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    wait_done("bp_timeout");
    run_op(8'h01, 8'h01, OP_ADD, 1'b0, 1'b0);
    check("after_bp", 64'(got_s), 64'h02);

    // Asynchronous reset three cycles into a MUL.
    @(negedge clk);
    a = 8'h13; b = 8'h25; op = OP_MUL; cin = 1'b0; b_inv = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_reset", {s, hi, pack_flags(c, zero, overflow, negative), 6'b0, out_valid, in_ready}, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #2 check("ready_post_release", 64'(in_ready), 64'd1);
    repeat (12) @(negedge clk);
    run_op(8'h02, 8'h03, OP_ADD, 1'b0, 1'b0);
    check("add_after_reset", 64'(got_s), 64'h05);

    // Randomized traffic.
    for (int i = 0; i < 300; i++) rand_op();

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
